// File: rtl/phase_controller_pkg.sv
// ctrl_pkg: shared state, opcode and mux-select encodings for the phase controller
package ctrl_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    localparam logic [1:0] OP_LD  = 2'b00;
    localparam logic [1:0] OP_ST  = 2'b01;
    localparam logic [1:0] OP_IMM = 2'b10;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ALU = 2'b11;

    localparam logic [2:0] OP2_LDI  = 3'b000;
    localparam logic [2:0] OP2_ADDI = 3'b001;
    localparam logic [2:0] OP2_SUBI = 3'b010;
    localparam logic [2:0] OP2_B    = 3'b100;
    localparam logic [2:0] OP2_BC   = 3'b111;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_CMP = 4'd5;
    localparam logic [3:0] ALU_MOV = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd8;
    localparam logic [3:0] ALU_SLR = 4'd9;
    localparam logic [3:0] ALU_SRL = 4'd10;
    localparam logic [3:0] ALU_SRR = 4'd11;
    localparam logic [3:0] ALU_HLT = 4'd15;

    localparam logic PC_SEL_INC = 1'b0;
    localparam logic PC_SEL_ALU = 1'b1;
    localparam logic WB_SEL_ALU = 1'b0;
    localparam logic WB_SEL_MEM = 1'b1;

endpackage

// File: rtl/phase_controller_if.sv
// phase_controller_if: memory bus between the sequencer (master) and memory (slave)
interface phase_controller_if #(parameter int WIDTH = 16);

    logic             mem_req;
    logic             mem_we;
    logic             addr_sel;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ready;

    modport master (output mem_req, output mem_we, output addr_sel,
                    input mem_rdata, input mem_ready);
    modport slave  (input mem_req, input mem_we, input addr_sel,
                    output mem_rdata, output mem_ready);

endinterface

// File: rtl/phase_controller_instr_class_decode.sv
// instr_class_decode: classifies the instruction register into control classes
module instr_class_decode
    import ctrl_pkg::*;
(
    input  logic [15:0] ir,
    output logic        is_load,
    output logic        is_store,
    output logic        writes_reg,
    output logic        writes_flags,
    output logic        is_branch,
    output logic        is_hlt
);

    logic [1:0] op1;
    logic [2:0] op2;
    logic [3:0] opc;
    logic       alu_arith;
    logic       unused_fields;

    assign op1 = ir[15:14];
    assign op2 = ir[13:11];
    assign opc = ir[7:4];
    assign unused_fields = ^{ir[10:8], ir[3:0]};

    // shifts 8-11 share flag/writeback behaviour with the arithmetic group
    assign alu_arith = (opc >= ALU_SLL) && (opc <= ALU_SRR);

    // class flags; HLT itself is recognised by the ALU, so only the ALU class qualifies it here
    always_comb begin
        is_load      = op1 == OP_LD;
        is_store     = op1 == OP_ST;
        writes_flags = (op1 == OP_ALU && (opc <= ALU_MOV || alu_arith))
                    || (op1 == OP_IMM && (op2 == OP2_ADDI || op2 == OP2_SUBI));
        writes_reg   = (op1 == OP_ALU && (opc <= ALU_XOR || opc == ALU_MOV || alu_arith))
                    || op1 == OP_LD
                    || (op1 == OP_IMM && (op2 == OP2_LDI || op2 == OP2_ADDI || op2 == OP2_SUBI));
        is_branch    = op1 == OP_BR && (op2 == OP2_B || op2 == OP2_BC);
        is_hlt       = op1 == OP_ALU;
    end

endmodule

// File: rtl/phase_controller.sv
// phase_controller: multi-cycle fetch/decode/execute/memory/writeback sequencer
module phase_controller
    import ctrl_pkg::*;
#(
    parameter int         WIDTH      = 16,
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               step_mode,
    phase_controller_if.master bus,
    input  logic               alu_s,
    input  logic               alu_z,
    input  logic               alu_c,
    input  logic               alu_v,
    input  logic               alu_hlt,
    output logic [WIDTH-1:0]   ir,
    output logic [3:0]         flags,
    output logic               alu_le,
    output logic               reg_we,
    output logic               wb_sel,
    output logic               pc_we,
    output logic               pc_sel,
    output logic [2:0]         phase,
    output logic               halted
);

    logic [2:0] state;
    logic [2:0] state_nx;
    logic       is_load;
    logic       is_store;
    logic       writes_reg;
    logic       writes_flags;
    logic       is_branch;
    logic       is_hlt;

    instr_class_decode u_dec (
        .ir           (ir[15:0]),
        .is_load      (is_load),
        .is_store     (is_store),
        .writes_reg   (writes_reg),
        .writes_flags (writes_flags),
        .is_branch    (is_branch),
        .is_hlt       (is_hlt)
    );

    // next-state selection; start, mem_ready and alu_hlt only matter in their own phases
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   state_nx = start ? ST_FETCH : ST_IDLE;
            ST_FETCH:  state_nx = bus.mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: state_nx = ST_EXEC;
            ST_EXEC:   state_nx = (alu_hlt && is_hlt) ? ST_HALT
                                : (is_load || is_store) ? ST_MEM : ST_WB;
            ST_MEM:    state_nx = bus.mem_ready ? ST_WB : ST_MEM;
            ST_WB:     state_nx = step_mode ? ST_IDLE : ST_FETCH;
            ST_HALT:   state_nx = start ? ST_FETCH : ST_HALT;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // state, instruction register and flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            ir    <= '0;
            flags <= FLAG_RESET;
        end else begin
            state <= state_nx;
            if (state == ST_FETCH && bus.mem_ready)
                ir <= bus.mem_rdata;
            if (state == ST_EXEC && writes_flags)
                flags <= {alu_s, alu_z, alu_c, alu_v};
        end
    end

    // strobes decoded from the current phase and instruction class
    always_comb begin
        bus.mem_req  = state == ST_FETCH || state == ST_MEM;
        bus.addr_sel = state == ST_MEM;
        bus.mem_we   = state == ST_MEM && is_store;
        alu_le       = state == ST_EXEC;
        reg_we       = state == ST_WB && writes_reg;
        wb_sel       = (state == ST_WB && is_load) ? WB_SEL_MEM : WB_SEL_ALU;
        pc_we        = (state == ST_FETCH && bus.mem_ready) || (state == ST_WB && is_branch);
        pc_sel       = (state == ST_WB && is_branch) ? PC_SEL_ALU : PC_SEL_INC;
        halted       = state == ST_HALT;
        phase        = state;
    end

endmodule

// File: tb/tb_phase_controller.sv
// tb_phase_controller: directed self-checking bench for the phase controller
module tb_phase_controller;

    localparam logic [2:0] P_IDLE = 3'd0, P_FETCH = 3'd1, P_DECODE = 3'd2,
                           P_EXEC = 3'd3, P_MEM = 3'd4, P_WB = 3'd5, P_HALT = 3'd6;

    logic        clk = 0;
    logic        rst = 1;
    logic        start = 0;
    logic        step_mode = 0;
    logic        alu_s = 0, alu_z = 0, alu_c = 0, alu_v = 0, alu_hlt = 0;
    logic [15:0] ir;
    logic [3:0]  flags;
    logic        alu_le, reg_we, wb_sel, pc_we, pc_sel, halted;
    logic [2:0]  phase;
    int          checks = 0;
    int          errors = 0;

    phase_controller_if #(.WIDTH(16)) bus ();

    phase_controller #(.WIDTH(16), .FLAG_RESET(4'b0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .step_mode (step_mode),
        .bus       (bus),
        .alu_s     (alu_s),
        .alu_z     (alu_z),
        .alu_c     (alu_c),
        .alu_v     (alu_v),
        .alu_hlt   (alu_hlt),
        .ir        (ir),
        .flags     (flags),
        .alu_le    (alu_le),
        .reg_we    (reg_we),
        .wb_sel    (wb_sel),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .phase     (phase),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {mem_req, mem_we, addr_sel, alu_le, reg_we, wb_sel, pc_we, pc_sel, halted}
    function automatic logic [8:0] strobes();
        return {bus.mem_req, bus.mem_we, bus.addr_sel, alu_le, reg_we, wb_sel, pc_we, pc_sel, halted};
    endfunction

    initial begin
        bus.mem_rdata = 16'h0000;
        bus.mem_ready = 0;
        tick();
        tick();
        rst = 0;
        chk("reset_phase", phase, P_IDLE);
        chk("reset_ir", ir, 16'h0000);
        chk("reset_flags", flags, 4'b0000);
        chk("reset_strobes", strobes(), 9'b0);

        // ADD: four-cycle ALU instruction, flags load in EXEC
        start = 1; bus.mem_ready = 1; bus.mem_rdata = 16'hCA00;
        {alu_s, alu_z, alu_c, alu_v} = 4'b1010;
        tick();
        start = 0;
        chk("add_fetch_phase", phase, P_FETCH);
        chk("add_fetch_strobes", strobes(), 9'b100000100);
        tick();
        chk("add_decode_phase", phase, P_DECODE);
        chk("add_ir", ir, 16'hCA00);
        chk("add_decode_strobes", strobes(), 9'b0);
        tick();
        chk("add_exec_phase", phase, P_EXEC);
        chk("add_exec_strobes", strobes(), 9'b000100000);
        chk("add_exec_flags_old", flags, 4'b0000);
        tick();
        chk("add_wb_phase", phase, P_WB);
        chk("add_wb_flags", flags, 4'b1010);
        chk("add_wb_strobes", strobes(), 9'b000010000);

        // CMP: flags update, no register write
        bus.mem_rdata = 16'hCA50;
        {alu_s, alu_z, alu_c, alu_v} = 4'b0100;
        tick();
        chk("cmp_fetch_phase", phase, P_FETCH);
        tick(); tick(); tick();
        chk("cmp_wb_phase", phase, P_WB);
        chk("cmp_flags", flags, 4'b0100);
        chk("cmp_wb_strobes", strobes(), 9'b0);

        // LD with three wait cycles in MEM
        bus.mem_rdata = 16'h0A05;
        {alu_s, alu_z, alu_c, alu_v} = 4'b1111;
        tick(); tick(); tick();
        chk("ld_exec_phase", phase, P_EXEC);
        bus.mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ld_mem_wait_phase", phase, P_MEM);
            chk("ld_mem_wait_strobes", strobes(), 9'b101000000);
        end
        bus.mem_ready = 1;
        chk("ld_mem_ready_strobes", strobes(), 9'b101000000);
        tick();
        chk("ld_wb_phase", phase, P_WB);
        chk("ld_wb_strobes", strobes(), 9'b000011000);
        chk("ld_flags_hold", flags, 4'b0100);

        // ST: five cycles with ready high, store strobe, no register write
        bus.mem_rdata = 16'h4A05;
        tick(); tick(); tick(); tick();
        chk("st_mem_phase", phase, P_MEM);
        chk("st_mem_strobes", strobes(), 9'b111000000);
        tick();
        chk("st_wb_phase", phase, P_WB);
        chk("st_wb_strobes", strobes(), 9'b0);

        // Branch: PC loads ALU result in WB, flags untouched
        bus.mem_rdata = 16'hA003;
        tick(); tick(); tick(); tick();
        chk("br_wb_phase", phase, P_WB);
        chk("br_wb_strobes", strobes(), 9'b000000110);
        chk("br_flags_hold", flags, 4'b0100);

        // HLT: park in HALT until start
        bus.mem_rdata = 16'hC0F0;
        tick(); tick(); tick();
        chk("hlt_exec_phase", phase, P_EXEC);
        alu_hlt = 1;
        tick();
        alu_hlt = 0;
        for (int i = 0; i < 10; i++) begin
            chk("halt_phase", phase, P_HALT);
            chk("halt_strobes", strobes(), 9'b000000001);
            tick();
        end
        chk("hlt_flags_hold", flags, 4'b0100);
        start = 1;
        tick();
        start = 0;
        chk("resume_phase", phase, P_FETCH);

        // Reset during a MEM wait
        bus.mem_rdata = 16'h0A05;
        tick(); tick();
        bus.mem_ready = 0;
        tick();
        chk("rst_pre_phase", phase, P_MEM);
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("rst_mem_phase", phase, P_IDLE);
        chk("rst_mem_ir", ir, 16'h0000);
        chk("rst_mem_flags", flags, 4'b0000);
        chk("rst_mem_strobes", strobes(), 9'b0);

        // Single-step: back to IDLE after one WB
        step_mode = 1; bus.mem_ready = 1; bus.mem_rdata = 16'hCA00; start = 1;
        tick();
        start = 0;
        tick(); tick(); tick();
        chk("step_wb_phase", phase, P_WB);
        tick();
        chk("step_idle_phase", phase, P_IDLE);
        tick();
        chk("step_idle_hold", phase, P_IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/phase_controller.md
Name: phase_controller

Overview:
Multi-cycle sequencer for the 16-bit core. It steps each instruction through fetch, decode, execute, memory and writeback. It owns the instruction register and the S/Z/C/V flag register feeding the ALU flag inputs. It drives the write enables and mux selects for the PC, register file and memory, and stops the core on HLT.

Parameters:
WIDTH, 16, instruction/data width
FLAG_RESET, 4'b0000, reset value of {S,Z,C,V}

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active high
start  in  1  leave IDLE/HALT and begin fetching
step_mode  in  1  1 = return to IDLE after each WB
mem_rdata  in  WIDTH  instruction/load data
mem_ready  in  1  memory access complete this cycle
alu_s, alu_z, alu_c, alu_v  in  1 each  ALU flag outputs
alu_hlt  in  1  ALU HLT decode
mem_req  out  1  memory access request
mem_we  out  1  1 = store
addr_sel  out  1  0 = PC, 1 = ALU result
ir  out  WIDTH  instruction register
flags  out  4  {S,Z,C,V} to ALU S_in/Z_in/C_in/V_in
alu_le  out  1  latch ALU result
reg_we  out  1  register file write
wb_sel  out  1  0 = ALU result, 1 = mem_rdata
pc_we  out  1  PC write
pc_sel  out  1  0 = PC+1, 1 = ALU result
phase  out  3  current state, for debug
halted  out  1  HALT state indicator

Behaviour:
- Instruction fields: op1=ir[15:14], op2=ir[13:11], alu opcode=ir[7:4].
- All state updates on posedge clk. rst has priority over every other input.
- Reset, including mid-instruction or mid-memory-wait: state=IDLE, ir=0, flags=FLAG_RESET. All strobes are 0 in the following cycle.
- All strobes are Moore/decoded outputs of the current state and ir. Every strobe defaults to 0.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: start=1 -> FETCH.
- FETCH: mem_req=1, addr_sel=0. Hold until mem_ready=1; that cycle ir<=mem_rdata, pc_we=1, pc_sel=0, go to DECODE. Wait length is unbounded.
- DECODE: one cycle, always -> EXEC.
- EXEC: alu_le=1.
  - flags<=ALU flags when op1=11 with opcode 0-6 or 8-11, or op1=10 with op2=001/010. Otherwise flags hold.
  - Next state: alu_hlt=1 with op1=11 -> HALT. op1=00/01 -> MEM. Else -> WB.
- MEM: mem_req=1, addr_sel=1, mem_we=(op1==01). Hold until mem_ready=1, then -> WB.
- WB:
  - reg_we=1 for op1=11 opcodes 0-4, 6, 8-11 (wb_sel=0); op1=00 (wb_sel=1); op1=10 op2=000/001/010 (wb_sel=0).
  - pc_we=1, pc_sel=1 for op1=10 op2=100/111. Branch condition is already resolved in the ALU result.
  - Next state: step_mode=1 -> IDLE, else -> FETCH.
- HALT: halted=1, no strobes. start=1 -> FETCH; resume uses the already incremented PC.
- Undefined encodings (op1=11 opcode 7/12-14, op1=10 op2=011) pass through with no reg/flag/pc write.
- Ignored inputs: start outside IDLE/HALT; mem_ready outside FETCH/MEM; alu_hlt outside EXEC.
- Latency with mem_ready tied high: 4 cycles per ALU/branch instruction, 5 per LD/ST.

Decomposition:
- Shared package ctrl_pkg holds: state enum; op1 codes (LD=00, ST=01, IMM/BR=10, ALU=11); op2 codes; ALU opcode constants (ADD=0 … SRR=11, HLT=15); pc_sel/wb_sel encodings.
- One sub-module, instr_class_decode: combinational ir -> {is_load, is_store, writes_reg, writes_flags, is_branch, is_hlt}.

Test Plan:
- Reset, then start=1, mem_ready=1, mem_rdata=0xCA00 (ADD) -> FETCH→DECODE→EXEC→WB in 4 cycles; flags load in EXEC; reg_we=1, wb_sel=0 in WB; pc_we=1 only in FETCH.
- mem_rdata=0xCA50 (CMP), alu_z=1 -> flags=4'b0100 after EXEC; reg_we stays 0 in WB.
- 0x0A05 (LD) with mem_ready low 3 cycles in MEM -> mem_req=1, addr_sel=1, mem_we=0 held 4 cycles; WB has reg_we=1, wb_sel=1. Repeat with 0x4A05 (ST) -> mem_we=1, reg_we=0.
- 0xA003 (B) -> WB has pc_we=1, pc_sel=1; flags unchanged.
- 0xC0F0 with alu_hlt=1 -> HALT, halted=1 with no strobes for 10 cycles; start=1 -> FETCH next cycle.
- rst asserted during MEM wait -> next cycle IDLE, ir=0, flags=0, mem_req=0. Separately, step_mode=1 -> IDLE after one WB.
